// File: rtl/run_length_detector.sv
// Serial run-length detector.
// Tracks the current run of identical bits on a qualified serial stream and
// flags when a run of ONES_LEN ones or ZEROS_LEN zeros completes. A runtime
// mode mask gates the flags and the saturating hit counter without affecting
// run tracking. OVERLAP selects between flagging every sample past the target
// length (1) or once per complete block of target length (0).
module run_length_detector #(
    parameter int ONES_LEN  = 3,
    parameter int ZEROS_LEN = 3,
    parameter int CNT_W     = 8,
    parameter int HIT_W     = 16,
    parameter int OVERLAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic [1:0]       mode,
    input  logic             clr_hits,
    output logic             y_ones,
    output logic             y_zeros,
    output logic             y,
    output logic             run_bit,
    output logic [CNT_W-1:0] run_cnt,
    output logic [HIT_W-1:0] hit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ONES  = 2'd1,
        S_ZEROS = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [HIT_W-1:0] HIT_MAX   = '1;
    localparam logic [CNT_W-1:0] ONES_TGT  = CNT_W'(ONES_LEN);
    localparam logic [CNT_W-1:0] ZEROS_TGT = CNT_W'(ZEROS_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] run_cnt_reg, run_cnt_next;
    logic             run_bit_reg, run_bit_next;
    logic             y_ones_reg, y_ones_next;
    logic             y_zeros_reg, y_zeros_next;
    logic             y_reg, y_next;
    logic [HIT_W-1:0] hit_cnt_reg, hit_cnt_next;

    // Intermediate values for the sample being accepted this cycle.
    logic             same_run;
    logic [CNT_W-1:0] cnt_new;
    logic [CNT_W-1:0] target;
    logic             hit;

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            run_cnt_reg <= '0;
            run_bit_reg <= 1'b0;
            y_ones_reg  <= 1'b0;
            y_zeros_reg <= 1'b0;
            y_reg       <= 1'b0;
            hit_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            run_cnt_reg <= run_cnt_next;
            run_bit_reg <= run_bit_next;
            y_ones_reg  <= y_ones_next;
            y_zeros_reg <= y_zeros_next;
            y_reg       <= y_next;
            hit_cnt_reg <= hit_cnt_next;
        end
    end

    // Next-state, run counting, hit detection and hit counter update.
    always_comb begin
        state_next   = state_reg;
        run_cnt_next = run_cnt_reg;
        run_bit_next = run_bit_reg;
        y_ones_next  = 1'b0;
        y_zeros_next = 1'b0;
        hit_cnt_next = hit_cnt_reg;
        same_run     = 1'b0;
        cnt_new      = '0;
        target       = '0;
        hit          = 1'b0;

        if (en) begin
            // A sample continues the run only if it matches the bit the
            // current state is tracking; IDLE never continues a run.
            same_run = (x && (state_reg == S_ONES)) || (!x && (state_reg == S_ZEROS));
            if (same_run) begin
                cnt_new = (run_cnt_reg == CNT_MAX) ? CNT_MAX : run_cnt_reg + CNT_ONE;
            end else begin
                cnt_new = CNT_ONE;
            end

            target = x ? ONES_TGT : ZEROS_TGT;
            if (OVERLAP != 0) begin
                hit = (cnt_new >= target);
            end else begin
                hit = (cnt_new == target);
            end

            state_next   = x ? S_ONES : S_ZEROS;
            run_bit_next = x;
            // Non-overlapping mode restarts the block count after each hit
            // while the state keeps following the bit value.
            run_cnt_next = (hit && (OVERLAP == 0)) ? '0 : cnt_new;

            y_ones_next  = hit && x && mode[0];
            y_zeros_next = hit && !x && mode[1];
        end

        y_next = y_ones_next | y_zeros_next;

        // Clear takes priority over a coincident hit.
        if (clr_hits) begin
            hit_cnt_next = '0;
        end else if (y_next && (hit_cnt_reg != HIT_MAX)) begin
            hit_cnt_next = hit_cnt_reg + HIT_W'(1);
        end
    end

    assign y_ones  = y_ones_reg;
    assign y_zeros = y_zeros_reg;
    assign y       = y_reg;
    assign run_bit = run_bit_reg;
    assign run_cnt = run_cnt_reg;
    assign hit_cnt = hit_cnt_reg;

endmodule
